// File: rtl/pa_lsu_flag_sram_ctrl_if.sv
// LSU flag SRAM controller bus: LSU request/response, invalidate-all handshake,
// and the active-low pin set of the 64x4 flag SPSRAM.
// slave  = the controller; master = its environment (LSU plus the SRAM macro).
interface pa_lsu_flag_sram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  inv_all_req;
  logic                  inv_all_done;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  req_vld, req_wr, req_idx, req_wmask, req_wdata, inv_all_req, sram_q,
    output req_rdy, rsp_vld, rsp_data, inv_all_done,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );

  modport master (
    output req_vld, req_wr, req_idx, req_wmask, req_wdata, inv_all_req, sram_q,
    input  req_rdy, rsp_vld, rsp_data, inv_all_done,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );
endinterface

// File: rtl/pa_lsu_flag_sram_ctrl.sv
// Access controller in front of the 64x4 LSU flag SPSRAM: single read/write
// requests, read data return, and a clear-all sweep after reset / invalidate-all.
// Optional macro PA_FLAG_SRAM_OUTREG_EN adds an output flop on read data
// (response latency 2 instead of 1).
module pa_lsu_flag_sram_ctrl (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  pa_lsu_flag_sram_ctrl_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 4;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {SWEEP, IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  rd_pipe_q, rd_pipe_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;

  logic                  rdy_c;
  logic                  cen_c;
  logic                  gwen_c;
  logic [DATA_WIDTH-1:0] wen_c;
  logic [ADDR_WIDTH-1:0] a_c;
  logic [DATA_WIDTH-1:0] d_c;

  // Next-state and SRAM pin decode; reset forces the pins idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rd_pipe_d = 1'b0;
    rdy_c     = 1'b0;
    cen_c     = 1'b1;
    gwen_c    = 1'b1;
    wen_c     = '1;
    a_c       = a_q;
    d_c       = d_q;
    case (state_q)
      SWEEP: begin
        cen_c  = 1'b0;
        gwen_c = 1'b0;
        wen_c  = '0;
        a_c    = cnt_q;
        d_c    = '0;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (bus.inv_all_req) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        rdy_c = ~bus.inv_all_req;
        if (bus.inv_all_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (bus.req_vld) begin
          if (!bus.req_wr) begin
            cen_c     = 1'b0;
            a_c       = bus.req_idx;
            rd_pipe_d = 1'b1;
          end else if (bus.req_wmask != '0) begin
            cen_c  = 1'b0;
            gwen_c = 1'b0;
            wen_c  = ~bus.req_wmask;
            a_c    = bus.req_idx;
            d_c    = bus.req_wdata;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
    if (cpurst) begin
      rdy_c  = 1'b0;
      cen_c  = 1'b1;
      gwen_c = 1'b1;
      wen_c  = '1;
      a_c    = '0;
      d_c    = '0;
    end
  end

  // State, sweep counter, done pulse, read pipe bit and address/data hold.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q   <= SWEEP;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_pipe_q <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_pipe_q <= rd_pipe_d;
      a_q       <= a_c;
      d_q       <= d_c;
    end
  end

  assign bus.req_rdy      = rdy_c;
  assign bus.sram_cen     = cen_c;
  assign bus.sram_gwen    = gwen_c;
  assign bus.sram_wen     = wen_c;
  assign bus.sram_a       = a_c;
  assign bus.sram_d       = d_c;
  assign bus.inv_all_done = done_q & ~cpurst;

`ifdef PA_FLAG_SRAM_OUTREG_EN
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // Capture SRAM read data; data holds until the next response.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= rd_pipe_q;
      if (rd_pipe_q) begin
        rsp_data_q <= bus.sram_q;
      end
    end
  end

  assign bus.rsp_vld  = rsp_vld_q & ~cpurst;
  assign bus.rsp_data = cpurst ? '0 : rsp_data_q;
`else
  assign bus.rsp_vld  = rd_pipe_q & ~cpurst;
  assign bus.rsp_data = (rd_pipe_q & ~cpurst) ? bus.sram_q : '0;
`endif
endmodule

// File: tb/tb_pa_lsu_flag_sram_ctrl.sv
// Directed bench for pa_lsu_flag_sram_ctrl with a behavioural 64x4 SPSRAM.
module tb_pa_lsu_flag_sram_ctrl;
`ifdef PA_FLAG_SRAM_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    int unsigned cyc;
    logic [3:0]  data;
  } rsp_t;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  mem [64];
  rsp_t        rsp_q [$];

  pa_lsu_flag_sram_ctrl_if bus ();

  pa_lsu_flag_sram_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .bus            (bus)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  // Behavioural SPSRAM: active-low CEN/GWEN/WEN, registered read data.
  always @(posedge forever_cpuclk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen) begin
        for (int b = 0; b < 4; b++)
          if (!bus.sram_wen[b]) mem[bus.sram_a][b] <= bus.sram_d[b];
      end else begin
        bus.sram_q <= mem[bus.sram_a];
      end
    end
  end

  // Response monitor: log every rsp_vld cycle with its data.
  always @(negedge forever_cpuclk) begin
    rsp_t r;
    #2;
    if (bus.rsp_vld) begin
      r.cyc  = cyc;
      r.data = bus.rsp_data;
      rsp_q.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge forever_cpuclk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.req_vld = 1'b0;
      bus.inv_all_req = 1'b0;
      #1;
    end
  endtask

  task automatic issue(input logic wr, input logic [5:0] idx, input logic [3:0] mask,
                       input logic [3:0] data, output int unsigned at);
    tick();
    bus.req_vld     = 1'b1;
    bus.req_wr      = wr;
    bus.req_idx     = idx;
    bus.req_wmask   = mask;
    bus.req_wdata   = data;
    bus.inv_all_req = 1'b0;
    #1;
    at = cyc;
  endtask

  task automatic expect_rsp(input string tag, input int unsigned issued, input logic [3:0] data);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      check({tag, " present"}, 32'd0, 32'd1);
    end else begin
      r = rsp_q.pop_front();
      check({tag, " latency"}, 32'(r.cyc - issued), 32'(LAT));
      check({tag, " data"}, 32'(r.data), 32'(data));
    end
  endtask

  // Entered at the negedge that starts sweep cycle 0 (inputs already set).
  task automatic verify_sweep(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      #1;
      check({tag, " sweep"},
            32'({bus.inv_all_done, bus.req_rdy, bus.sram_cen, bus.sram_gwen,
                 bus.sram_wen, bus.sram_a, bus.sram_d}),
            32'({1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 6'(i), 4'h0}));
    end
    tick();
    #1;
    check({tag, " done"}, 32'(bus.inv_all_done), 32'd1);
    check({tag, " rdy"}, 32'(bus.req_rdy), 32'd1);
    check({tag, " idle cen"}, 32'(bus.sram_cen), 32'd1);
    tick();
    #1;
    check({tag, " done pulse"}, 32'(bus.inv_all_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t0, t1, t2;
    logic [3:0] idle_data;

    for (int i = 0; i < 64; i++) mem[i] = 4'hA;
    bus.sram_q      = 4'h0;
    bus.req_vld     = 1'b0;
    bus.req_wr      = 1'b0;
    bus.req_idx     = '0;
    bus.req_wmask   = '0;
    bus.req_wdata   = '0;
    bus.inv_all_req = 1'b0;
    cpurst          = 1'b1;

    // Reset held for 3 cycles: everything idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("reset idle",
            32'({bus.req_rdy, bus.rsp_vld, bus.rsp_data, bus.inv_all_done, bus.sram_cen,
                 bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d}),
            32'({1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 6'd0, 4'h0}));
    end
    tick();
    cpurst = 1'b0;
    verify_sweep("init");

    // Masked write then read of idx 5.
    issue(1'b1, 6'd5, 4'b1010, 4'b1111, t);
    check("wr5 rdy", 32'(bus.req_rdy), 32'd1);
    check("wr5 pins", 32'({bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d}),
          32'({1'b0, 1'b0, 4'b0101, 6'd5, 4'hF}));
    issue(1'b0, 6'd5, 4'h0, 4'h0, t);
    check("rd5 pins", 32'({bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a}),
          32'({1'b0, 1'b1, 4'hF, 6'd5}));
    idle_cycles(3);
    expect_rsp("rd5", t, 4'b1010);
    check("idle hold pins", 32'({bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d}),
          32'({1'b1, 1'b1, 4'hF, 6'd5, 4'hF}));
`ifdef PA_FLAG_SRAM_OUTREG_EN
    idle_data = 4'b1010;
`else
    idle_data = 4'h0;
`endif
    check("idle rsp_data", 32'(bus.rsp_data), 32'(idle_data));

    // Back-to-back writes then back-to-back reads.
    issue(1'b1, 6'd0, 4'hF, 4'h3, t);
    issue(1'b1, 6'd1, 4'hF, 4'h6, t);
    issue(1'b1, 6'd2, 4'hF, 4'h9, t);
    issue(1'b0, 6'd0, 4'h0, 4'h0, t0);
    issue(1'b0, 6'd1, 4'h0, 4'h0, t1);
    issue(1'b0, 6'd2, 4'h0, 4'h0, t2);
    idle_cycles(3);
    expect_rsp("b2b rd0", t0, 4'h3);
    expect_rsp("b2b rd1", t1, 4'h6);
    expect_rsp("b2b rd2", t2, 4'h9);

    // Zero-mask write: accepted, no SRAM access, entry unchanged.
    issue(1'b1, 6'd5, 4'h0, 4'h5, t);
    check("wm0 rdy", 32'(bus.req_rdy), 32'd1);
    check("wm0 cen", 32'(bus.sram_cen), 32'd1);
    issue(1'b0, 6'd5, 4'h0, 4'h0, t);
    idle_cycles(3);
    expect_rsp("wm0 readback", t, 4'b1010);

    // Invalidate-all beats a same-cycle read request.
    tick();
    bus.req_vld = 1'b1;
    bus.req_wr = 1'b0;
    bus.req_idx = 6'd5;
    bus.inv_all_req = 1'b1;
    #1;
    check("inv prio rdy", 32'(bus.req_rdy), 32'd0);
    check("inv prio cen", 32'(bus.sram_cen), 32'd1);
    tick();
    bus.req_vld = 1'b0;
    bus.inv_all_req = 1'b0;
    verify_sweep("inv");
    issue(1'b0, 6'd5, 4'h0, 4'h0, t);
    idle_cycles(3);
    expect_rsp("inv readback", t, 4'h0);

    // Invalidate-all at cnt=40 restarts the sweep.
    tick();
    bus.inv_all_req = 1'b1;
    #1;
    tick();
    bus.inv_all_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    bus.inv_all_req = 1'b1;
    #1;
    check("restart a40", 32'({bus.sram_cen, bus.sram_a}), 32'({1'b0, 6'd40}));
    tick();
    bus.inv_all_req = 1'b0;
    verify_sweep("restart");

    // Reset at cnt=20 idles the pins and restarts the sweep.
    tick();
    bus.inv_all_req = 1'b1;
    #1;
    tick();
    bus.inv_all_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("midrst a20", 32'(bus.sram_a), 32'd20);
    cpurst = 1'b1;
    #1;
    check("midrst idle",
          32'({bus.req_rdy, bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d}),
          32'({1'b0, 1'b1, 1'b1, 4'hF, 6'd0, 4'h0}));
    tick();
    cpurst = 1'b0;
    verify_sweep("midrst");

    idle_cycles(2);
    check("no stray rsp", 32'(rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
